// File: rtl/bcd_display_pkg.sv
// Shared types and helpers for the multiplexed 7-segment BCD display scanner.
package bcd_display_pkg;

    typedef logic [3:0] bcd_digit_t;

    localparam bcd_digit_t BCD_BLANK = 4'hF;

    // Callers truncate the result to their own digit count (up to 32 digits).
    function automatic logic [31:0] onehot(input int unsigned idx);
        onehot = 32'd1 << idx;
    endfunction

endpackage

// File: rtl/bcd_display_scanner_tick_divider.sv
// Prescaler: counts 0..PRESCALE-1 while enabled and pulses tick on the terminal count.
module tick_divider #(
    parameter int PRESCALE = 50000
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic tick
);

    localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        tick  = en && (cnt_q == CW'(PRESCALE - 1));
        cnt_d = cnt_q;
        if (tick)
            cnt_d = '0;
        else if (en)
            cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

endmodule

// File: rtl/bcd_display_scanner.sv
// Time-multiplexed BCD display scanner with double-buffered frame and optional
// leading-zero blanking.
module bcd_display_scanner
    import bcd_display_pkg::*;
#(
    parameter int NUM_DIGITS    = 4,
    parameter int PRESCALE      = 50000,
    parameter int BLANK_LEADING = 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          enable,
    input  logic                          load,
    input  logic [4*NUM_DIGITS-1:0]       digits_in,
    input  logic [NUM_DIGITS-1:0]         dp_in,
    output logic [3:0]                    bcd_out,
    output logic [NUM_DIGITS-1:0]         an,
    output logic                          dp_out,
    output logic [$clog2(NUM_DIGITS)-1:0] digit_idx,
    output logic                          frame_done
);

    localparam int IW = $clog2(NUM_DIGITS);

    logic                    tick;
    logic                    wrap;
    logic [IW-1:0]           idx_q, idx_d;
    logic [4*NUM_DIGITS-1:0] act_digits_q, act_digits_d;
    logic [NUM_DIGITS-1:0]   act_dp_q, act_dp_d;
    logic [4*NUM_DIGITS-1:0] pend_digits_q, pend_digits_d;
    logic [NUM_DIGITS-1:0]   pend_dp_q, pend_dp_d;
    logic                    pend_vld_q, pend_vld_d;
    logic                    frame_done_q, frame_done_d;
    logic [NUM_DIGITS-1:0]   blank;
    logic                    zero_above;
    bcd_digit_t              cur_digit;

    tick_divider #(.PRESCALE(PRESCALE)) u_div (
        .clk  (clk),
        .rst  (rst),
        .en   (enable),
        .tick (tick)
    );

    assign wrap = tick && (idx_q == IW'(NUM_DIGITS - 1));

    always_comb begin
        idx_d         = idx_q;
        act_digits_d  = act_digits_q;
        act_dp_d      = act_dp_q;
        pend_digits_d = pend_digits_q;
        pend_dp_d     = pend_dp_q;
        pend_vld_d    = pend_vld_q;
        frame_done_d  = wrap;
        if (tick)
            idx_d = wrap ? '0 : idx_q + 1'b1;
        // A load landing on the boundary itself goes straight to the active frame.
        if (wrap) begin
            pend_vld_d = 1'b0;
            if (load) begin
                act_digits_d = digits_in;
                act_dp_d     = dp_in;
            end else if (pend_vld_q) begin
                act_digits_d = pend_digits_q;
                act_dp_d     = pend_dp_q;
            end
        end else if (load) begin
            pend_digits_d = digits_in;
            pend_dp_d     = dp_in;
            pend_vld_d    = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q         <= '0;
            act_digits_q  <= '0;
            act_dp_q      <= '0;
            pend_digits_q <= '0;
            pend_dp_q     <= '0;
            pend_vld_q    <= 1'b0;
            frame_done_q  <= 1'b0;
        end else begin
            idx_q         <= idx_d;
            act_digits_q  <= act_digits_d;
            act_dp_q      <= act_dp_d;
            pend_digits_q <= pend_digits_d;
            pend_dp_q     <= pend_dp_d;
            pend_vld_q    <= pend_vld_d;
            frame_done_q  <= frame_done_d;
        end
    end

    // Walk down from the most significant digit; blank while everything above is zero.
    always_comb begin
        zero_above = 1'b1;
        blank      = '0;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            zero_above = zero_above && (act_digits_q[4*i +: 4] == 4'd0);
            blank[i]   = (BLANK_LEADING != 0) && zero_above;
        end
    end

    assign cur_digit = act_digits_q[{idx_q, 2'b00} +: 4];

    always_comb begin
        an      = '0;
        bcd_out = BCD_BLANK;
        dp_out  = 1'b0;
        if (rst) begin
            bcd_out = '0;
        end else if (enable) begin
            an      = NUM_DIGITS'(onehot(32'(idx_q)));
            bcd_out = blank[idx_q] ? BCD_BLANK : cur_digit;
            dp_out  = act_dp_q[idx_q];
        end
    end

    assign digit_idx  = idx_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_bcd_display_scanner.sv
// Directed + random bench for bcd_display_scanner against a frame-level reference model.
module tb_bcd_display_scanner;

    localparam int NUM_DIGITS = 4;
    localparam int PRESCALE   = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b1;
    logic        load = 1'b0;
    logic [15:0] digits_in = '0;
    logic [3:0]  dp_in = '0;

    logic [3:0] bcd_out, bcd_out_nb;
    logic [3:0] an, an_nb;
    logic       dp_out, dp_out_nb;
    logic [1:0] digit_idx, digit_idx_nb;
    logic       frame_done, frame_done_nb;

    int checks = 0;
    int failures = 0;

    // reference model state
    int m_cnt, m_idx;
    int m_act[NUM_DIGITS], m_actdp[NUM_DIGITS];
    int m_pend[NUM_DIGITS], m_penddp[NUM_DIGITS];
    bit m_pv, m_fd;

    bcd_display_scanner #(.NUM_DIGITS(NUM_DIGITS), .PRESCALE(PRESCALE), .BLANK_LEADING(1)) dut (
        .clk(clk), .rst(rst), .enable(enable), .load(load), .digits_in(digits_in), .dp_in(dp_in),
        .bcd_out(bcd_out), .an(an), .dp_out(dp_out), .digit_idx(digit_idx), .frame_done(frame_done)
    );

    bcd_display_scanner #(.NUM_DIGITS(NUM_DIGITS), .PRESCALE(PRESCALE), .BLANK_LEADING(0)) dut_nb (
        .clk(clk), .rst(rst), .enable(enable), .load(load), .digits_in(digits_in), .dp_in(dp_in),
        .bcd_out(bcd_out_nb), .an(an_nb), .dp_out(dp_out_nb), .digit_idx(digit_idx_nb),
        .frame_done(frame_done_nb)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_update();
        bit tick, wrap;
        if (rst) begin
            m_cnt = 0; m_idx = 0; m_pv = 0; m_fd = 0;
            for (int i = 0; i < NUM_DIGITS; i++) begin
                m_act[i] = 0; m_actdp[i] = 0; m_pend[i] = 0; m_penddp[i] = 0;
            end
        end else begin
            tick = enable && (m_cnt == PRESCALE - 1);
            wrap = tick && (m_idx == NUM_DIGITS - 1);
            m_fd = wrap;
            if (wrap) begin
                for (int i = 0; i < NUM_DIGITS; i++) begin
                    if (load) begin
                        m_act[i] = int'(digits_in[4*i +: 4]); m_actdp[i] = int'(dp_in[i]);
                    end else if (m_pv) begin
                        m_act[i] = m_pend[i]; m_actdp[i] = m_penddp[i];
                    end
                end
                m_pv = 0;
            end else if (load) begin
                for (int i = 0; i < NUM_DIGITS; i++) begin
                    m_pend[i] = int'(digits_in[4*i +: 4]); m_penddp[i] = int'(dp_in[i]);
                end
                m_pv = 1;
            end
            if (enable) m_cnt = tick ? 0 : m_cnt + 1;
            if (tick) m_idx = (m_idx + 1) % NUM_DIGITS;
        end
    endtask

    // One clock: advance the model with the inputs seen at the edge, then compare.
    task automatic step();
        int msd, e_an, e_bcd, e_bcd_nb, e_dp;
        @(posedge clk);
        model_update();
        #1;
        msd = 0;
        for (int i = 0; i < NUM_DIGITS; i++) if (m_act[i] != 0) msd = i;
        if (rst) begin
            e_an = 0; e_bcd = 0; e_bcd_nb = 0; e_dp = 0;
        end else if (!enable) begin
            e_an = 0; e_bcd = 15; e_bcd_nb = 15; e_dp = 0;
        end else begin
            e_an = 1 << m_idx;
            e_bcd_nb = m_act[m_idx];
            e_bcd = (m_idx > msd) ? 15 : m_act[m_idx];
            e_dp = m_actdp[m_idx];
        end
        chk("an", 32'(an), e_an);
        chk("bcd_out", 32'(bcd_out), e_bcd);
        chk("dp_out", 32'(dp_out), e_dp);
        chk("digit_idx", 32'(digit_idx), m_idx);
        chk("frame_done", 32'(frame_done), 32'(m_fd));
        chk("bcd_out_noblank", 32'(bcd_out_nb), e_bcd_nb);
        chk("an_noblank", 32'(an_nb), e_an);
        chk("dp_out_noblank", 32'(dp_out_nb), e_dp);
        chk("digit_idx_noblank", 32'(digit_idx_nb), m_idx);
        chk("frame_done_noblank", 32'(frame_done_nb), 32'(m_fd));
    endtask

    task automatic steps(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    task automatic do_load(input logic [15:0] d, input logic [3:0] dp);
        load = 1'b1; digits_in = d; dp_in = dp;
        step();
        load = 1'b0;
    endtask

    task automatic wait_frame(input string tag);
        for (int k = 0; k < 40; k++) begin
            step();
            if (frame_done === 1'b1) break;
        end
        chk(tag, 32'(frame_done), 1);
    endtask

    task automatic wait_state(input int idx, input int cnt, input string tag);
        bit found = 0;
        for (int k = 0; k < 40; k++) begin
            if (m_idx == idx && m_cnt == cnt) begin found = 1; break; end
            step();
        end
        chk(tag, 32'(found), 1);
    endtask

    initial begin
        // 1. reset and release
        steps(3);
        chk("rst_an", 32'(an), 0);
        chk("rst_bcd", 32'(bcd_out), 0);
        rst = 1'b0;
        #1;
        chk("release_an", 32'(an), 1);
        chk("release_bcd", 32'(bcd_out), 0);
        steps(4);
        chk("t1_an_after4", 32'(an), 2);

        // 2. mid-frame load applied at the wrap
        steps(6);
        do_load(16'h1234, 4'b0000);
        wait_frame("t2_wait");
        chk("t2_first_bcd", 32'(bcd_out), 4);
        chk("t2_first_an", 32'(an), 1);
        steps(16);
        chk("t2_frame_period", 32'(frame_done), 1);

        // 3. leading-zero blanking
        do_load(16'h0070, 4'b0000);
        wait_frame("t3_wait_a");
        chk("t3_d0", 32'(bcd_out), 0);
        steps(4);
        chk("t3_d1", 32'(bcd_out), 7);
        steps(4);
        chk("t3_d2_blank", 32'(bcd_out), 15);
        chk("t3_d2_noblank", 32'(bcd_out_nb), 0);
        steps(8);
        do_load(16'h0000, 4'b0000);
        wait_frame("t3_wait_b");
        steps(16);

        // 4. enable gating freezes the scan
        wait_state(1, 2, "t4_wait");
        enable = 1'b0;
        #1;
        chk("t4_dark_an", 32'(an), 0);
        chk("t4_dark_bcd", 32'(bcd_out), 15);
        steps(10);
        chk("t4_idx_hold", 32'(digit_idx), 1);
        enable = 1'b1;
        steps(8);

        // 5. load in the wrap cycle, then two loads within one frame
        wait_state(3, 3, "t5_wait");
        do_load(16'h5678, 4'b0000);
        chk("t5_bypass_fd", 32'(frame_done), 1);
        chk("t5_bypass_bcd", 32'(bcd_out), 8);
        steps(5);
        do_load(16'h1111, 4'b0000);
        steps(3);
        do_load(16'h2222, 4'b0000);
        wait_frame("t5_wait_b");
        chk("t5_last_wins", 32'(bcd_out), 2);
        steps(16);

        // 6. decimal point, then reset with a pending frame
        do_load(16'h9876, 4'b0100);
        wait_frame("t6_wait");
        steps(16);
        wait_state(2, 0, "t6_wait_d2");
        do_load(16'hABCD, 4'b1111);
        rst = 1'b1;
        step();
        chk("t6_rst_idx", 32'(digit_idx), 0);
        rst = 1'b0;
        steps(20);

        // random phase
        for (int c = 0; c < 600; c++) begin
            logic [15:0] d;
            for (int i = 0; i < NUM_DIGITS; i++)
                d[4*i +: 4] = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
            load = ($urandom_range(0, 7) == 0);
            digits_in = d;
            dp_in = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 9) == 0) enable = ~enable;
            rst = ($urandom_range(0, 99) == 0);
            step();
        end
        load = 1'b0; rst = 1'b0; enable = 1'b1;
        steps(4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bcd_display_scanner.md
Name: bcd_display_scanner

Overview:
Time-multiplexed driver for a multi-digit common-segment 7-segment display.
- Holds a frame of BCD digits and cycles through them at a programmable refresh rate.
- Presents one BCD digit at a time to the downstream BCD-to-7-segment decoder, plus a one-hot digit-enable and decimal point.
- Optionally blanks leading zeros.
- Digit updates take effect only at frame boundaries, so the display never shows a partly updated value.

Parameters:
NUM_DIGITS, 4, number of display digits (>=2)
PRESCALE, 50000, clk cycles each digit stays enabled (>=1)
BLANK_LEADING, 1, 1 = replace leading zero digits with the blank code; 0 = show all digits

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  synchronous reset, active-high
enable  input  1  1 = scanning; 0 = display dark, scan state frozen
load  input  1  single-cycle strobe; capture digits_in/dp_in into the pending frame
digits_in  input  4*NUM_DIGITS  BCD digits, digit 0 (least significant) at [3:0]
dp_in  input  NUM_DIGITS  decimal point per digit, bit i = digit i
bcd_out  output  4  BCD code of the selected digit, to the decoder; 4'hF = blank
an  output  NUM_DIGITS  one-hot digit enable, active-high
dp_out  output  1  decimal point of the selected digit
digit_idx  output  $clog2(NUM_DIGITS)  index of the selected digit
frame_done  output  1  one-cycle pulse when the index wraps from NUM_DIGITS-1 to 0

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on rst; no other reset.
- Reset state: prescaler=0, digit_idx=0, active frame=0, pending frame=0, pending_valid=0, frame_done=0.
  - While rst is high: an=0, bcd_out=0, dp_out=0.
- Prescaler: counts 0..PRESCALE-1 while enable=1. At the terminal count:
  - prescaler wraps to 0;
  - digit_idx advances by 1, modulo NUM_DIGITS.
  - PRESCALE=1: advance every cycle.
- Outputs are combinational from registered state, with no added latency.
  - enable=1: an=one-hot(digit_idx).
  - bcd_out = active digit[digit_idx], or 4'hF if that digit is blanked.
  - dp_out = active dp[digit_idx].
- enable=0: an=0, dp_out=0, bcd_out=4'hF.
  - Prescaler and digit_idx hold their values. Scanning resumes from the same count when enable returns to 1.
  - load is still accepted while enable=0.
- Load:
  - load=1 captures digits_in/dp_in into the pending frame and sets pending_valid.
  - A later load before the next boundary overwrites the pending frame (last value wins).
- Frame boundary is the cycle where digit_idx wraps NUM_DIGITS-1 -> 0.
  - If pending_valid: active frame <= pending frame, pending_valid <= 0.
  - frame_done asserts in the cycle digit_idx becomes 0.
- load in the boundary cycle: digits_in bypasses directly into the active frame; pending_valid stays 0.
- Blanking, with BLANK_LEADING=1:
  - Digit i (i>=1) is blanked if active digit i and all digits above it equal 0.
  - Digit 0 is never blanked.
  - The dp bit does not affect blanking; dp_out is still driven on a blanked digit.
- Non-BCD digit values (0xA-0xF) are passed through unchanged; the decoder shows them dark.
- rst mid-frame: all state returns to reset values on the next edge and the pending frame is discarded.

Decomposition:
- Package bcd_display_pkg holds:
  - typedef bcd_digit_t = logic [3:0];
  - constant BCD_BLANK = 4'hF;
  - function onehot(idx) returning the an vector.
- One sub-module, tick_divider (parameter PRESCALE; ports clk, rst, en, tick): produces the terminal-count pulse.
- Leading-zero detection and frame registers stay in the top module.

Test Plan (NUM_DIGITS=4, PRESCALE=4, BLANK_LEADING=1 unless noted):
1. Reset:
   - rst=1 for 3 cycles -> an=0000, bcd_out=0, frame_done=0.
   - Release with enable=1 -> an=0001, bcd_out=0, and an=0010 after 4 cycles.
2. Load and update at boundary:
   - load digits_in=16'h1234 mid-frame -> old digits shown until the wrap.
   - Next frame shows: an 0001/bcd 4, 0010/3, 0100/2, 1000/1, each held 4 cycles.
   - frame_done pulses every 16 cycles.
3. Leading-zero blanking:
   - load 16'h0070 -> digits 3 and 2 show bcd_out=F; digit 1 shows 7; digit 0 shows 0.
   - load 16'h0000 -> digits 3..1 show F; digit 0 shows 0.
   - Same stimulus with BLANK_LEADING=0 -> 0,0,7,0 shown.
4. Enable gating:
   - enable=0 at cycle 2 of digit 1 -> an=0000, bcd_out=F, digit_idx stays 1.
   - enable=1 after 10 cycles -> an=0010 for the remaining 2 cycles, then 0100.
5. Load collisions:
   - load 16'h5678 in the wrap cycle -> frame starting next cycle shows 8,7,6,5.
   - Two loads (16'h1111 then 16'h2222) within one frame -> only 2222 is displayed.
6. dp and reset mid-operation:
   - dp_in=4'b0100 -> dp_out=1 only while an=0100.
   - rst during digit 2 -> next cycle digit_idx=0, active frame 0, pending frame discarded.
